// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR pattern generator / MISR compactor.
// Primitive feedback masks: bit i set means the old MSB is folded into new bit i.
package lfsr_pkg;

  localparam logic [31:0] SEED_DEFAULT = 32'h0000_0001;

  localparam logic [2:0]  POLY3  = 3'b101;
  localparam logic [3:0]  POLY4  = 4'b1001;
  localparam logic [4:0]  POLY5  = 5'b01001;
  localparam logic [5:0]  POLY6  = 6'b100001;
  localparam logic [6:0]  POLY7  = 7'b1000001;
  localparam logic [7:0]  POLY8  = 8'b00011101;
  localparam logic [8:0]  POLY9  = 9'b000100001;
  localparam logic [9:0]  POLY10 = 10'b0010000001;
  localparam logic [10:0] POLY11 = 11'b01000000001;
  localparam logic [11:0] POLY12 = 12'h053;
  localparam logic [12:0] POLY13 = 13'h001B;
  localparam logic [13:0] POLY14 = 14'h0443;
  localparam logic [14:0] POLY15 = 15'h4001;
  localparam logic [15:0] POLY16 = 16'h6801;
  localparam logic [16:0] POLY17 = 17'h04001;
  localparam logic [17:0] POLY18 = 18'h00801;
  localparam logic [18:0] POLY19 = 19'h00047;
  localparam logic [19:0] POLY20 = 20'h20001;
  localparam logic [20:0] POLY21 = 21'h080001;
  localparam logic [21:0] POLY22 = 22'h200001;
  localparam logic [22:0] POLY23 = 23'h040001;
  localparam logic [23:0] POLY24 = 24'hC20001;
  localparam logic [24:0] POLY25 = 25'h0400001;
  localparam logic [25:0] POLY26 = 26'h0000047;
  localparam logic [26:0] POLY27 = 27'h0000027;
  localparam logic [27:0] POLY28 = 28'h2000001;
  localparam logic [28:0] POLY29 = 29'h08000001;
  localparam logic [29:0] POLY30 = 30'h00000053;
  localparam logic [30:0] POLY31 = 31'h10000001;
  localparam logic [31:0] POLY32 = 32'h00400007;

  // Default primitive mask for a given width, zero-extended to 32 bits.
  function automatic logic [31:0] prim_poly(input int unsigned width);
    case (width)
      3:       return 32'(POLY3);
      4:       return 32'(POLY4);
      5:       return 32'(POLY5);
      6:       return 32'(POLY6);
      7:       return 32'(POLY7);
      8:       return 32'(POLY8);
      9:       return 32'(POLY9);
      10:      return 32'(POLY10);
      11:      return 32'(POLY11);
      12:      return 32'(POLY12);
      13:      return 32'(POLY13);
      14:      return 32'(POLY14);
      15:      return 32'(POLY15);
      16:      return 32'(POLY16);
      17:      return 32'(POLY17);
      18:      return 32'(POLY18);
      19:      return 32'(POLY19);
      20:      return 32'(POLY20);
      21:      return 32'(POLY21);
      22:      return 32'(POLY22);
      23:      return 32'(POLY23);
      24:      return 32'(POLY24);
      25:      return 32'(POLY25);
      26:      return 32'(POLY26);
      27:      return 32'(POLY27);
      28:      return 32'(POLY28);
      29:      return 32'(POLY29);
      30:      return 32'(POLY30);
      31:      return 32'(POLY31);
      32:      return POLY32;
      default: return 32'h0000_0001;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational Galois step: shift left, fold MSB through POLY, optionally XOR din (MISR).
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned          WIDTH = 6,
  parameter logic [WIDTH-1:0]     POLY  = WIDTH'(prim_poly(WIDTH))
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] din,
  input  logic             misr_en,
  output logic [WIDTH-1:0] nxt_c
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0);
    nxt_c   = misr_en ? (shifted ^ din) : shifted;
  end

endmodule

// File: rtl/lfsr_gen.sv
// Galois LFSR / MISR with seed load, all-zero lock-up recovery and period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned          WIDTH = 6,
  parameter logic [WIDTH-1:0]     POLY  = WIDTH'(prim_poly(WIDTH)),
  parameter logic [WIDTH-1:0]     SEED  = WIDTH'(SEED_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             misr_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             lock_rcv,
  output logic [WIDTH-1:0] period,
  output logic             period_vld
);

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] step_c;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] start_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic             period_vld_nxt;
  logic             lock_rcv_nxt;

  lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .q       (q),
    .din     (din),
    .misr_en (misr_en),
    .nxt_c   (step_c)
  );

  // Priority: load, MISR step, lock-up recovery, plain step; otherwise hold.
  always_comb begin
    q_nxt          = q;
    start_nxt      = start;
    cnt_nxt        = cnt;
    period_nxt     = period;
    period_vld_nxt = period_vld;
    lock_rcv_nxt   = 1'b0;

    if (ld) begin
      q_nxt          = seed_in;
      start_nxt      = seed_in;
      cnt_nxt        = '0;
      period_vld_nxt = 1'b0;
    end else if (en) begin
      if (misr_en) begin
        q_nxt          = step_c;
        cnt_nxt        = '0;
        period_vld_nxt = 1'b0;
      end else if (q == '0) begin
        q_nxt        = SEED;
        start_nxt    = SEED;
        cnt_nxt      = '0;
        lock_rcv_nxt = 1'b1;
      end else begin
        q_nxt = step_c;
        // Returning to the start state closes one full cycle.
        if (step_c == start) begin
          period_nxt     = cnt + WIDTH'(1);
          period_vld_nxt = 1'b1;
          cnt_nxt        = '0;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q          <= SEED;
      start      <= SEED;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      lock_rcv   <= 1'b0;
    end else begin
      q          <= q_nxt;
      start      <= start_nxt;
      cnt        <= cnt_nxt;
      period     <= period_nxt;
      period_vld <= period_vld_nxt;
      lock_rcv   <= lock_rcv_nxt;
    end
  end

endmodule
